// File: rtl/mips64_pkg.sv
// Shared definitions for the HI/LO divide controller: datapath width, opcodes
// and the controller state encoding.
package mips64_pkg;

    localparam int WIDTH = 64;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FIXUP,
        DRAIN
    } div_state_t;

endpackage

// File: rtl/hilo_div_ctrl_sign_mag.sv
// Conditional two's-complement negate, used both for operand magnitudes and
// for restoring the sign of divider results.
module sign_mag #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? -value : value;

endmodule

// File: rtl/hilo_div_ctrl.sv
// Issue/writeback controller around an unsigned multi-cycle divider: turns
// DIV/DIVU into magnitude divides, fixes up signs and commits to HI/LO.
module hilo_div_ctrl
    import mips64_pkg::*;
#(
    parameter int WIDTH = mips64_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_rs,
    input  logic [WIDTH-1:0] req_rt,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_ready
);

    div_state_t       state;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic             is_signed;
    logic             neg_a;
    logic             neg_b;

    assign is_signed = (req_op == OP_DIV);
    assign neg_a     = is_signed & req_rs[WIDTH-1];
    assign neg_b     = is_signed & req_rt[WIDTH-1];

    sign_mag #(.WIDTH(WIDTH)) u_mag_a (.value(req_rs), .neg(neg_a),  .result(mag_a));
    sign_mag #(.WIDTH(WIDTH)) u_mag_b (.value(req_rt), .neg(neg_b),  .result(mag_b));
    sign_mag #(.WIDTH(WIDTH)) u_fix_q (.value(q_r),    .neg(sign_q), .result(fix_q));
    sign_mag #(.WIDTH(WIDTH)) u_fix_r (.value(r_r),    .neg(sign_r), .result(fix_r));

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    // A flush in LAUNCH must keep the divider from ever starting.
    assign div_start = (state == LAUNCH) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            div_a  <= '0;
            div_b  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            q_r    <= '0;
            r_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        case (req_op)
                            OP_MTHI: hi <= req_rs;
                            OP_MTLO: lo <= req_rs;
                            OP_DIV, OP_DIVU: begin
                                // Zero divisor is resolved here without touching the divider.
                                if (req_rt == '0) begin
                                    hi <= req_rs;
                                    lo <= '1;
                                end else begin
                                    sign_q <= neg_a ^ neg_b;
                                    sign_r <= neg_a;
                                    div_a  <= mag_a;
                                    div_b  <= mag_b;
                                    state  <= LAUNCH;
                                end
                            end
                        endcase
                    end
                end
                LAUNCH: state <= flush ? IDLE : WAIT;
                WAIT: begin
                    if (flush) begin
                        state <= div_ready ? IDLE : DRAIN;
                    end else if (div_ready) begin
                        q_r   <= div_quotient;
                        r_r   <= div_remainder;
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (!flush) begin
                        lo <= fix_q;
                        hi <= fix_r;
                    end
                    state <= IDLE;
                end
                DRAIN: begin
                    // The divider is still running the cancelled op; swallow its result.
                    if (div_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Randomised self-checking bench for hilo_div_ctrl with a transaction-level
// reference model and a behavioural divider that answers div_start.
module tb_hilo_div_ctrl;
    import mips64_pkg::*;

    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_rs;
    logic [63:0] req_rt;
    logic        flush;
    logic        busy;
    logic [63:0] hi;
    logic [63:0] lo;
    logic        div_start;
    logic [63:0] div_a;
    logic [63:0] div_b;
    logic [63:0] div_quotient;
    logic [63:0] div_remainder;
    logic        div_ready;

    hilo_div_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .flush(flush), .busy(busy),
        .hi(hi), .lo(lo),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural divider
    int          dlat = 3;
    int          dcnt = 0;
    logic [63:0] dq, dr;
    bit          stray_en = 0;
    int          start_cnt = 0;

    // Reference model: architectural HI/LO plus the progress of one divide
    logic [63:0] m_hi, m_lo;
    bit          launch_now, waiting, commit_now, draining;
    logic [63:0] exp_q, exp_r, exp_a, exp_b;

    // Values observed in the most recent cycle
    logic        s_ready, s_busy, s_start;
    logic [63:0] s_a, s_b, s_hi, s_lo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return launch_now | waiting | commit_now | draining;
    endfunction

    function automatic logic [63:0] mag(input bit sgn, input logic [63:0] v);
        longint x;
        x = v;
        if (sgn && x < 0) return 64'(-x);
        return v;
    endfunction

    // Architectural result: truncating division, remainder takes dividend sign
    task automatic ref_div(input bit sgn, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r);
        longint sa, sb;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == MIN && b == ONES) begin
            q = MIN;
            r = 64'd0;
        end else begin
            sa = a;
            sb = b;
            q = 64'(sa / sb);
            r = 64'(sa % sb);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0;
        launch_now = 0; waiting = 0; commit_now = 0; draining = 0;
    endtask

    task automatic model_step();
        bit sgn;
        if (!m_busy()) begin
            if (req_valid && !flush) begin
                case (req_op)
                    OP_MTHI: m_hi = req_rs;
                    OP_MTLO: m_lo = req_rs;
                    default: begin
                        if (req_rt == 64'd0) begin
                            m_hi = req_rs;
                            m_lo = ONES;
                        end else begin
                            sgn = (req_op == OP_DIV);
                            ref_div(sgn, req_rs, req_rt, exp_q, exp_r);
                            exp_a = mag(sgn, req_rs);
                            exp_b = mag(sgn, req_rt);
                            launch_now = 1;
                        end
                    end
                endcase
            end
        end else if (launch_now) begin
            launch_now = 0;
            waiting = !flush;
        end else if (waiting) begin
            if (flush) begin
                waiting = 0;
                draining = !div_ready;
            end else if (div_ready) begin
                waiting = 0;
                commit_now = 1;
            end
        end else if (commit_now) begin
            commit_now = 0;
            if (!flush) begin
                m_lo = exp_q;
                m_hi = exp_r;
            end
        end else if (draining) begin
            if (div_ready) draining = 0;
        end
    endtask

    task automatic compare();
        chk("req_ready", {63'd0, req_ready}, {63'd0, !m_busy()});
        chk("busy", {63'd0, busy}, {63'd0, m_busy()});
        chk("div_start", {63'd0, div_start}, {63'd0, launch_now && !flush});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (launch_now || waiting) begin
            chk("div_a", div_a, exp_a);
            chk("div_b", div_b, exp_b);
        end
    endtask

    task automatic tick(input bit v, input logic [1:0] op, input logic [63:0] rs,
                        input logic [63:0] rt, input bit fl);
        @(negedge clk);
        div_ready = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                div_ready = 1'b1;
                div_quotient = dq;
                div_remainder = dr;
            end
        end else if (stray_en && !m_busy() && $urandom_range(0, 15) == 0) begin
            div_ready = 1'b1;
            div_quotient = {$urandom, $urandom};
            div_remainder = {$urandom, $urandom};
        end
        req_valid = v; req_op = op; req_rs = rs; req_rt = rt; flush = fl;
        #1;
        compare();
        s_ready = req_ready; s_busy = busy; s_start = div_start;
        s_a = div_a; s_b = div_b; s_hi = hi; s_lo = lo;
        if (div_start) begin
            start_cnt++;
            dq = (div_b == 0) ? ONES : div_a / div_b;
            dr = (div_b == 0) ? div_a : div_a % div_b;
            dcnt = dlat;
        end
        model_step();
    endtask

    task automatic idle();
        tick(0, OP_DIVU, 64'd0, 64'd0, 0);
    endtask

    task automatic drain_idle(input string name);
        int n = 0;
        while (s_busy && n < 40) begin
            idle();
            n++;
        end
        chk(name, {63'd0, s_busy}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 0; flush = 0; div_ready = 0; dcnt = 0;
        model_reset();
        #1;
        compare();
        chk("rst_div_a", div_a, 64'd0);
        chk("rst_div_b", div_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rv();
        case ($urandom_range(0, 5))
            0: return 64'($urandom_range(0, 20));
            1: return -64'($urandom_range(1, 20));
            2: begin
                case ($urandom_range(0, 4))
                    0: return MIN;
                    1: return MAX;
                    2: return ONES;
                    3: return 64'd0;
                    default: return 64'd1;
                endcase
            end
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int sc;
        bit acc;
        rst_n = 1'b0;
        req_valid = 0; req_op = OP_DIVU; req_rs = 0; req_rt = 0; flush = 0;
        div_ready = 0; div_quotient = 0; div_remainder = 0;
        s_busy = 0;
        model_reset();
        @(negedge clk);
        #1;
        compare();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", hi, 64'd0);
        chk("rst_lo", lo, 64'd0);
        chk("rst_div_start", {63'd0, div_start}, 64'd0);
        chk("rst_div_a", div_a, 64'd0);
        chk("rst_div_b", div_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // DIVU 100 / 7
        dlat = 5;
        sc = start_cnt;
        tick(1, OP_DIVU, 64'd100, 64'd7, 0);
        idle();
        chk("divu_start", {63'd0, s_start}, 64'd1);
        chk("divu_a", s_a, 64'd100);
        chk("divu_b", s_b, 64'd7);
        drain_idle("divu_timeout");
        chk("divu_lo", s_lo, 64'd14);
        chk("divu_hi", s_hi, 64'd2);
        chk("divu_start_count", 64'(start_cnt - sc), 64'd1);

        // DIV -7 / 2
        dlat = 2;
        tick(1, OP_DIV, -64'd7, 64'd2, 0);
        idle();
        chk("div_neg_a", s_a, 64'd7);
        chk("div_neg_b", s_b, 64'd2);
        drain_idle("div_neg_timeout");
        chk("div_neg_lo", s_lo, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_neg_hi", s_hi, ONES);

        // Divide by zero
        sc = start_cnt;
        tick(1, OP_DIV, 64'd5, 64'd0, 0);
        idle();
        chk("dz_busy", {63'd0, s_busy}, 64'd0);
        chk("dz_hi", s_hi, 64'd5);
        chk("dz_lo", s_lo, ONES);
        chk("dz_no_start", 64'(start_cnt - sc), 64'd0);

        // Overflow MIN / -1
        dlat = 3;
        tick(1, OP_DIV, MIN, ONES, 0);
        idle();
        chk("ovf_a", s_a, MIN);
        chk("ovf_b", s_b, 64'd1);
        drain_idle("ovf_timeout");
        chk("ovf_lo", s_lo, MIN);
        chk("ovf_hi", s_hi, 64'd0);

        // Flush while waiting on the divider
        tick(1, OP_MTHI, 64'd3, 64'd0, 0);
        tick(1, OP_MTLO, 64'd4, 64'd0, 0);
        dlat = 6;
        tick(1, OP_DIVU, 64'd50, 64'd3, 0);
        idle();
        idle();
        tick(0, OP_DIVU, 64'd0, 64'd0, 1);
        drain_idle("flush_timeout");
        chk("flush_hi", s_hi, 64'd3);
        chk("flush_lo", s_lo, 64'd4);
        chk("flush_divider_idle", 64'(dcnt), 64'd0);

        // MTHI held valid while a divide is in flight
        dlat = 4;
        tick(1, OP_DIVU, 64'd9, 64'd2, 0);
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1, OP_MTHI, 64'hAA, 64'd0, 0);
            if (s_ready) begin
                acc = 1;
                break;
            end
        end
        chk("mthi_hold_accept", {63'd0, acc}, 64'd1);
        idle();
        chk("mthi_hold_hi", s_hi, 64'hAA);
        chk("mthi_hold_lo", s_lo, 64'd4);

        // Random traffic with flushes, stray ready pulses and one mid-run reset
        stray_en = 1;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            dlat = $urandom_range(1, 6);
            tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rv(), rv(),
                 $urandom_range(0, 19) == 0);
        end
        stray_en = 0;
        drain_idle("final_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
Issue and writeback controller directly upstream and downstream of the 64-bit divider.
- Accepts DIV/DIVU/MTHI/MTLO requests from the execute stage.
- Converts signed operands to magnitudes, launches the divider and waits for its ready pulse.
- Applies sign fix-up and commits quotient to LO and remainder to HI.
- Holds the pipeline off through req_ready and busy while a divide is in flight.

Parameters:
WIDTH, 64, operand/HI/LO width
OP_DIV, 2'b00, signed divide opcode
OP_DIVU, 2'b01, unsigned divide opcode
OP_MTHI, 2'b10, write HI from rs
OP_MTLO, 2'b11, write LO from rs

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (state==IDLE)
req_op  in  2  opcode
req_rs  in  WIDTH  dividend / move source
req_rt  in  WIDTH  divisor
flush  in  1  pipeline flush, cancels in-flight divide
busy  out  1  divide in flight (LAUNCH/WAIT/FIXUP/DRAIN)
hi  out  WIDTH  HI register (remainder)
lo  out  WIDTH  LO register (quotient)
div_start  out  1  one-cycle launch pulse to divider
div_a  out  WIDTH  unsigned dividend magnitude
div_b  out  WIDTH  unsigned divisor magnitude
div_quotient  in  WIDTH  divider quotient
div_remainder  in  WIDTH  divider remainder
div_ready  in  1  one-cycle pulse: quotient/remainder valid this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: hi=0, lo=0, div_start=0, div_a=0, div_b=0, busy=0, state=IDLE, req_ready=1.
- Accept: a request is accepted on a cycle with req_valid & req_ready & !flush. If flush and req_valid are high together, flush wins and the request is dropped.
- MTHI/MTLO: on accept, hi (or lo) <= req_rs at the next edge. State stays IDLE. Single cycle.
- DIV/DIVU on accept:
  - Latch sign_q = signed & (rs[63]^rt[63]) and sign_r = signed & rs[63].
  - div_a <= signed&rs[63] ? -rs : rs; div_b likewise from rt. This is two's-complement negate; -2^63 maps to 0x8000_0000_0000_0000 unsigned.
  - Go to LAUNCH.
- Divide by zero (rt==0): the divider is never started. hi <= rs, lo <= all ones, regardless of signedness. Takes one cycle; state stays IDLE.
- LAUNCH: div_start=1 for exactly this cycle; next state WAIT.
- WAIT: hold div_a/div_b stable. On div_ready, capture the results into internal q/r registers and go to FIXUP.
- FIXUP:
  - lo <= sign_q ? -q : q; hi <= sign_r ? -r : r. Next state IDLE.
  - Total latency from accept to hi/lo update = divider latency + 3 edges.
  - busy falls the cycle after the hi/lo update.
- Overflow: -2^63 / -1 gives q=2^63; the negate wraps, so lo=0x8000_0000_0000_0000 and hi=0. No trap.
- Flush by state:
  - In LAUNCH: div_start is suppressed; go to IDLE.
  - In WAIT: go to DRAIN.
  - In FIXUP: the commit is cancelled and hi/lo are unchanged; go to IDLE.
  - In DRAIN: no effect.
- DRAIN: req_ready=0, busy=1. The next div_ready pulse is discarded and the state returns to IDLE. A div_ready arriving in the same cycle as the flush in WAIT is also discarded and the state goes straight to IDLE.
- Stray div_ready in IDLE, LAUNCH or FIXUP is ignored.
- Reset mid-operation: all state returns to reset values immediately. The divider is reset by the same rst_n.

Decomposition:
- Shared package (mips64_pkg) holds:
  - the opcode constants OP_*;
  - the state enum IDLE/LAUNCH/WAIT/FIXUP/DRAIN;
  - WIDTH.
- One sub-module: sign_mag, a combinational conditional negate (in: value, neg; out: neg ? -value : value). It is instanced four times: two operand magnitudes and two result fix-ups.
- The divider itself stays a separate instance wired at the next level up.

Test Plan:
- DIVU rs=100, rt=7, divider model returns after 5 cycles:
  - div_start pulses once with div_a=100, div_b=7;
  - lo=14, hi=2;
  - req_ready low from accept until the cycle after commit.
- DIV rs=-7, rt=2:
  - div_a=7, div_b=2;
  - lo=0xFFFF_FFFF_FFFF_FFFD (-3), hi=0xFFFF_FFFF_FFFF_FFFF (-1).
- DIV rs=5, rt=0:
  - no div_start;
  - next cycle hi=5, lo=0xFFFF_FFFF_FFFF_FFFF;
  - busy never asserts.
- DIV rs=0x8000_0000_0000_0000, rt=-1:
  - div_a=0x8000_0000_0000_0000, div_b=1;
  - lo=0x8000_0000_0000_0000, hi=0.
- Flush in WAIT after a prior commit left hi=3, lo=4:
  - DRAIN entered and req_ready stays 0 until the pulse;
  - the late div_ready pulse is discarded;
  - hi=3, lo=4 unchanged;
  - IDLE and req_ready=1 the cycle after the pulse.
- MTHI with rs=0xAA held valid while a DIV is in WAIT:
  - not accepted (req_ready=0);
  - accepted the cycle after busy falls, giving hi=0xAA with lo unchanged from the divide.
